// File: rtl/icache_pkg.sv
// icache_pkg: state encoding, AXI response code and geometry helpers shared by the icache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_AR,
    MISS_R,
    RESP
  } state_e;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  // Address split: {tag, index, offset}; a line is BEATS fetch words.
  function automatic int calc_offset(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_index(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag(input int addr_w, input int num_sets, input int line_bytes);
    return addr_w - $clog2(num_sets) - $clog2(line_bytes);
  endfunction

  function automatic int calc_beats(input int line_bytes, input int fetch_w);
    return (line_bytes * 8) / fetch_w;
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch request/response channel, fence.i flush and AXI4 read port of the icache.
// Latency: n/a (wires only).
// Backpressure: req_ready on fetch side, arready/rready on AXI side; responses have none.
// Modports: slave = cache side, master = IFU + memory side.
interface icache_sa_if #(
  parameter int ADDR_W  = 32,
  parameter int FETCH_W = 64
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               resp_valid;
  logic [FETCH_W-1:0] resp_data;
  logic               resp_err;
  logic               flush;
  logic               mem_arvalid;
  logic               mem_arready;
  logic [ADDR_W-1:0]  mem_araddr;
  logic [7:0]         mem_arlen;
  logic               mem_rvalid;
  logic               mem_rready;
  logic [FETCH_W-1:0] mem_rdata;
  logic [1:0]         mem_rresp;
  logic               mem_rlast;

  modport slave (
    input  req_valid, req_addr, flush, mem_arready, mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
    output req_ready, resp_valid, resp_data, resp_err, mem_arvalid, mem_araddr, mem_arlen, mem_rready
  );

  modport master (
    output req_valid, req_addr, flush, mem_arready, mem_rvalid, mem_rdata, mem_rresp, mem_rlast,
    input  req_ready, resp_valid, resp_data, resp_err, mem_arvalid, mem_araddr, mem_arlen, mem_rready
  );
endinterface

// File: rtl/icache_way_tags.sv
// icache_way_tags: valid/tag store for one way plus its tag comparator.
// Latency: hit is combinational from idx/lookup_tag; writes take effect at the next edge.
// Backpressure: none; inv_all has priority over a same-cycle write.
// Ports: clk, rst (async active-low), idx, lookup_tag, hit, wr_en, wr_valid, wr_tag, inv_all.
module icache_way_tags #(
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = 6,
  parameter int TAG_W    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic               wr_valid,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               inv_all
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[idx] <= wr_valid;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[idx] <= wr_tag;
    end
  end

  assign hit = valid_q[idx] && (tag_q[idx] == lookup_tag);

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative read-only instruction cache with AXI4 burst refill and round-robin replacement.
// Latency: hit answers 1 cycle after accept (1 fetch/cycle back-to-back); miss answers the cycle after rlast.
// Backpressure: req_ready drops on miss, refill and flush; responses are single-cycle pulses with no backpressure.
// Ports: clk, rst (async active-low), bus (icache_sa_if.slave: fetch req/resp, flush, AXI AR/R).
module icache_sa
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FETCH_W    = 64,
  parameter int LINE_BYTES = 64,
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2
) (
  input logic        clk,
  input logic        rst,
  icache_sa_if.slave bus
);

  localparam int OFFSET   = calc_offset(LINE_BYTES);
  localparam int INDEX    = calc_index(NUM_SETS);
  localparam int TAG      = calc_tag(ADDR_W, NUM_SETS, LINE_BYTES);
  localparam int BEATS    = calc_beats(LINE_BYTES, FETCH_W);
  localparam int WORD_LSB = $clog2(FETCH_W / 8);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [WAY_W-1:0]    victim_q;
  logic [WAY_W-1:0]    rr_q [NUM_SETS];
  logic [BEAT_W-1:0]   k_q;
  logic                line_full_q;
  logic                err_q;
  logic                flush_pend_q;
  logic [FETCH_W-1:0]  data_q [NUM_SETS][NUM_WAYS][BEATS];

  logic [TAG-1:0]      tag_f;
  logic [INDEX-1:0]    idx_f;
  logic [BEAT_W-1:0]   beat_f;
  logic                unused_addr_lsb;

  logic [NUM_WAYS-1:0] hit, hit_oh;
  logic                hit_any;
  logic [FETCH_W-1:0]  hit_word, fill_word;
  logic                req_ready, resp_valid, ar_valid, r_ready;
  logic                tag_wr, tag_wr_valid, inv_all;
  logic                accept, beat_fire;

  assign tag_f           = addr_q[ADDR_W-1 -: TAG];
  assign idx_f           = addr_q[OFFSET +: INDEX];
  assign beat_f          = addr_q[WORD_LSB +: BEAT_W];
  assign unused_addr_lsb = ^addr_q[WORD_LSB-1:0];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    icache_way_tags #(
      .NUM_SETS (NUM_SETS),
      .INDEX_W  (INDEX),
      .TAG_W    (TAG)
    ) u_tags (
      .clk        (clk),
      .rst        (rst),
      .idx        (idx_f),
      .lookup_tag (tag_f),
      .hit        (hit[w]),
      .wr_en      (tag_wr && (victim_q == WAY_W'(w))),
      .wr_valid   (tag_wr_valid),
      .wr_tag     (tag_f),
      .inv_all    (inv_all)
    );
  end

  // At most one way can hit; isolating the lowest set bit keeps the mux one-hot regardless.
  assign hit_oh  = hit & (~hit + NUM_WAYS'(1));
  assign hit_any = |hit;

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_oh[w]) hit_word = hit_word | data_q[idx_f][w][beat_f];
    end
  end

  assign fill_word = data_q[idx_f][victim_q][beat_f];
  assign accept    = bus.req_valid && req_ready;
  assign beat_fire = (state_q == MISS_R) && bus.mem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    tag_wr       = 1'b0;
    tag_wr_valid = 1'b0;
    inv_all      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !bus.flush;
        inv_all   = bus.flush;
        if (bus.req_valid && !bus.flush) state_d = LOOKUP;
      end
      LOOKUP: begin
        inv_all = bus.flush;
        if (hit_any) begin
          resp_valid = 1'b1;
          req_ready  = !bus.flush;
          state_d    = (bus.req_valid && !bus.flush) ? LOOKUP : IDLE;
        end else begin
          state_d = MISS_AR;
        end
      end
      MISS_AR: begin
        ar_valid = 1'b1;
        if (bus.mem_arready) state_d = MISS_R;
      end
      MISS_R: begin
        // The burst always runs to rlast so the AXI transaction is never cut short.
        r_ready = 1'b1;
        if (bus.mem_rvalid && bus.mem_rlast) state_d = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        // The victim's data has been overwritten, so its entry is rewritten even when
        // it must not become valid; leaving the old tag valid would alias new data.
        tag_wr       = 1'b1;
        tag_wr_valid = !err_q && !flush_pend_q && !bus.flush;
        inv_all      = flush_pend_q || bus.flush;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      victim_q     <= '0;
      k_q          <= '0;
      line_full_q  <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else begin
      if (accept) addr_q <= bus.req_addr;

      if (state_q == LOOKUP && !hit_any) begin
        victim_q    <= rr_q[idx_f];
        k_q         <= '0;
        line_full_q <= 1'b0;
        err_q       <= 1'b0;
      end

      if (beat_fire) begin
        if (bus.mem_rresp != AXI_OKAY) err_q <= 1'b1;
        // Beats beyond a full line (over-long burst) are drained but not stored.
        if (!line_full_q) begin
          k_q <= k_q + BEAT_W'(1);
          if (k_q == BEAT_W'(BEATS - 1)) line_full_q <= 1'b1;
        end
      end

      if ((state_q == MISS_AR || state_q == MISS_R) && bus.flush) flush_pend_q <= 1'b1;
      else if (state_q == RESP)                                   flush_pend_q <= 1'b0;

      if (state_q == RESP) begin
        rr_q[idx_f] <= (NUM_WAYS == 1) ? '0 : rr_q[idx_f] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire && !line_full_q) data_q[idx_f][victim_q][k_q] <= bus.mem_rdata;
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_data   = resp_valid ? ((state_q == RESP) ? fill_word : hit_word) : '0;
  assign bus.resp_err    = (state_q == RESP) && err_q;
  assign bus.mem_arvalid = ar_valid;
  assign bus.mem_araddr  = {tag_f, idx_f, {OFFSET{1'b0}}};
  assign bus.mem_arlen   = 8'(BEATS - 1);
  assign bus.mem_rready  = r_ready;

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed scoreboard bench for icache_sa with default geometry (2 ways, 64 sets, 64 B lines).
// Memory beat b of line L returns {L ^ 0x80000000, b}, so lines at 0x80000000 return the beat index.
// Expected responses are queued when a request is driven and compared when resp_valid pulses.
module tb_icache_sa;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_sa_if #(.ADDR_W(32), .FETCH_W(64)) bus ();

  icache_sa #(
    .ADDR_W     (32),
    .FETCH_W    (64),
    .LINE_BYTES (64),
    .NUM_SETS   (64),
    .NUM_WAYS   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ar_cnt = 0;

  function automatic logic [63:0] beat_data(input logic [31:0] line, input int b);
    return {line ^ 32'h8000_0000, 32'(b)};
  endfunction

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return beat_data(a & 32'hFFFF_FFC0, int'(a[5:3]));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Response scoreboard and AR handshake counter.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.mem_arvalid && bus.mem_arready) ar_cnt++;
    if (rst && bus.resp_valid) begin
      chk("resp_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_err", 64'(bus.resp_err), 64'(e.err));
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic err, input bit hold,
                        output int waits, output logic rv);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    exp_q.push_back('{data: word_of(a), err: err});
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (bus.req_ready) break;
      waits++;
      if (waits > 100) begin
        chk("req_accept_timeout", 64'(waits), 64'(0));
        break;
      end
    end
    rv = bus.resp_valid;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] line, input int err_beat, input int flush_beat,
                       input int rst_beat);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.mem_arvalid) break;
      n++;
      if (n > 20) begin
        chk("ar_timeout", 64'(n), 64'(0));
        return;
      end
    end
    chk("araddr", 64'(bus.mem_araddr), 64'(line));
    chk("arlen", 64'(bus.mem_arlen), 64'(7));
    bus.mem_arready = 1'b1;
    @(posedge clk); #1;
    bus.mem_arready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beat_data(line, b);
      bus.mem_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      bus.mem_rlast  = (b == 7);
      bus.flush      = (b == flush_beat);
      if (b == rst_beat) begin
        rst = 1'b0;
        #1;
        chk("rst_arvalid", 64'(bus.mem_arvalid), 64'(0));
        chk("rst_rready", 64'(bus.mem_rready), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
        bus.mem_rvalid = 1'b0;
        bus.mem_rlast  = 1'b0;
        bus.mem_rresp  = 2'b00;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      n = 0;
      while (1) begin
        @(negedge clk);
        if (bus.mem_rready) break;
        n++;
        if (n > 20) begin
          chk("rready_timeout", 64'(n), 64'(0));
          bus.mem_rvalid = 1'b0;
          bus.flush      = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    bus.mem_rresp  = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic miss_req(input logic [31:0] a, input int err_beat, input int flush_beat,
                          input int rst_beat, input logic exp_err);
    int   w;
    logic rv;
    do_req(a, exp_err, 1'b0, w, rv);
    serve(a & 32'hFFFF_FFC0, err_beat, flush_beat, rst_beat);
    if (rst_beat < 0) drain();
  endtask

  task automatic hit_req(input logic [31:0] a, input string tag);
    int   w;
    int   ar0;
    logic rv;
    ar0 = ar_cnt;
    do_req(a, 1'b0, 1'b0, w, rv);
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(bus.resp_valid), 64'(1));
    drain();
    chk({tag, "_no_ar"}, 64'(ar_cnt), 64'(ar0));
  endtask

  initial begin
    int   w;
    logic rv;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.flush       = 1'b0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rresp   = 2'b00;
    bus.mem_rlast   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_resp_err", 64'(bus.resp_err), 64'(0));
    chk("rst_arvalid", 64'(bus.mem_arvalid), 64'(0));
    chk("rst_rready", 64'(bus.mem_rready), 64'(0));
    chk("rst_resp_data", bus.resp_data, 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Cold miss then re-hit
    miss_req(32'h8000_0008, -1, -1, -1, 1'b0);
    hit_req(32'h8000_0008, "cold_rehit");

    // Back-to-back hits with req_valid held
    do_req(32'h8000_0000, 1'b0, 1'b1, w, rv);
    do_req(32'h8000_0008, 1'b0, 1'b1, w, rv);
    chk("b2b_wait1", 64'(w), 64'(0));
    chk("b2b_resp1", 64'(rv), 64'(1));
    do_req(32'h8000_0010, 1'b0, 1'b0, w, rv);
    chk("b2b_wait2", 64'(w), 64'(0));
    chk("b2b_resp2", 64'(rv), 64'(1));
    @(negedge clk);
    chk("b2b_resp3", 64'(bus.resp_valid), 64'(1));
    chk("b2b_ready3", 64'(bus.req_ready), 64'(1));
    drain();

    // Associativity and round-robin replacement in set 0
    miss_req(32'h8000_1000, -1, -1, -1, 1'b0);
    hit_req(32'h8000_0000, "assoc_hit_a");
    hit_req(32'h8000_1000, "assoc_hit_b");
    miss_req(32'h8000_2000, -1, -1, -1, 1'b0);
    hit_req(32'h8000_1000, "assoc_keep_b");
    miss_req(32'h8000_0000, -1, -1, -1, 1'b0);

    // Error refill is answered with resp_err and not cached
    miss_req(32'h8000_3018, 3, -1, -1, 1'b1);
    miss_req(32'h8000_3018, -1, -1, -1, 1'b0);
    hit_req(32'h8000_3018, "err_refetch_hit");

    // Flush during refill: answered, not cached
    miss_req(32'h8000_4010, -1, 2, -1, 1'b0);
    miss_req(32'h8000_4010, -1, -1, -1, 1'b0);

    // Flush in IDLE with four resident lines
    miss_req(32'h8000_0000, -1, -1, -1, 1'b0);
    miss_req(32'h8000_0040, -1, -1, -1, 1'b0);
    miss_req(32'h8000_0080, -1, -1, -1, 1'b0);
    miss_req(32'h8000_00C0, -1, -1, -1, 1'b0);
    hit_req(32'h8000_0040, "preflush_hit");
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    bus.flush = 1'b0;
    miss_req(32'h8000_0000, -1, -1, -1, 1'b0);
    miss_req(32'h8000_0040, -1, -1, -1, 1'b0);
    miss_req(32'h8000_0080, -1, -1, -1, 1'b0);
    miss_req(32'h8000_00C0, -1, -1, -1, 1'b0);

    // Reset during beat 5 of a refill, then everything misses
    miss_req(32'h8000_0100, -1, -1, 5, 1'b0);
    miss_req(32'h8000_0000, -1, -1, -1, 1'b0);
    miss_req(32'h8000_0040, -1, -1, -1, 1'b0);
    hit_req(32'h8000_0040, "post_rst_hit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
